// File: rtl/dual_ram.sv
// rtl/dual_ram.sv - simple dual-port register-file RAM with registered read and async clear
//
// Ports:
//   din     [DATA_W-1:0] in  : write data
//   dout    [DATA_W-1:0] out : registered read data, one-cycle latency
//   rd_addr [ADDR_W-1:0] in  : read address
//   wr_addr [ADDR_W-1:0] in  : write address
//   clk                  in  : rising-edge clock
//   we                   in  : write enable, active high
//   re                   in  : read enable, active high; dout holds when low
//   as_clr               in  : asynchronous active-high clear of dout and all words

module dual_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic              as_clr
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;

  logic wr_in_range;
  logic rd_in_range;

  // Only matters when DEPTH is not a full power of two; at defaults both are always 1.
  assign wr_in_range = (32'(wr_addr) < 32'(DEPTH));
  assign rd_in_range = (32'(rd_addr) < 32'(DEPTH));

  always_comb begin
    mem_d = mem_q;
    if (we && wr_in_range) begin
      mem_d[wr_addr] = din;
    end
  end

  // Reads sample mem_q (pre-write contents), which gives read-before-write
  // when both ports hit the same word in one cycle.
  always_comb begin
    dout_d = dout_q;
    if (re) begin
      dout_d = rd_in_range ? mem_q[rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or posedge as_clr) begin
    if (as_clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_dual_ram.sv
// tb/tb_dual_ram.sv - self-checking bench for dual_ram

module tb_dual_ram;

  logic [15:0] din;
  logic [15:0] dout;
  logic [2:0]  rd_addr;
  logic [2:0]  wr_addr;
  logic        clk;
  logic        we;
  logic        re;
  logic        as_clr;

  int n_cmp;
  int n_bad;

  logic [15:0] mdl_mem [8];
  logic [15:0] mdl_dout;

  typedef struct {
    string       name;
    logic        w;
    logic        r;
    logic [2:0]  wa;
    logic [2:0]  ra;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [14];

  dual_ram #(.DATA_W(16), .ADDR_W(3), .DEPTH(8)) dut (
    .din     (din),
    .dout    (dout),
    .rd_addr (rd_addr),
    .wr_addr (wr_addr),
    .clk     (clk),
    .we      (we),
    .re      (re),
    .as_clr  (as_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: dout=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl_mem[i] = 16'h0000;
    mdl_dout = 16'h0000;
  endtask

  // Apply inputs, take one rising edge, advance the model, land 1 time unit past the edge.
  task automatic step(input logic w, input logic r, input logic [2:0] wa,
                      input logic [2:0] ra, input logic [15:0] d);
    logic [15:0] old;
    we = w; re = r; wr_addr = wa; rd_addr = ra; din = d;
    @(posedge clk);
    if (!as_clr) begin
      old = mdl_mem[ra];
      if (r) mdl_dout = old;
      if (w) mdl_mem[wa] = d;
    end
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    we = 0; re = 0; wr_addr = 0; rd_addr = 0; din = 0;
    as_clr = 1'b0;

    tbl[0]  = '{"wr5",          1'b1, 1'b0, 3'd5, 3'd0, 16'h3524, 16'h0000};
    tbl[1]  = '{"rd5",          1'b0, 1'b1, 3'd0, 3'd5, 16'h0000, 16'h3524};
    tbl[2]  = '{"wr2_a5a5",     1'b1, 1'b0, 3'd2, 3'd0, 16'hA5A5, 16'h3524};
    tbl[3]  = '{"rbw_same",     1'b1, 1'b1, 3'd2, 3'd2, 16'h1234, 16'hA5A5};
    tbl[4]  = '{"rd2_new",      1'b0, 1'b1, 3'd0, 3'd2, 16'h0000, 16'h1234};
    tbl[5]  = '{"wr7_ffff",     1'b1, 1'b0, 3'd7, 3'd0, 16'hFFFF, 16'h1234};
    tbl[6]  = '{"wr0_0001",     1'b1, 1'b0, 3'd0, 3'd0, 16'h0001, 16'h1234};
    tbl[7]  = '{"rd7",          1'b0, 1'b1, 3'd0, 3'd7, 16'h0000, 16'hFFFF};
    tbl[8]  = '{"rd0",          1'b0, 1'b1, 3'd0, 3'd0, 16'h0000, 16'h0001};
    tbl[9]  = '{"wr3_beef",     1'b1, 1'b0, 3'd3, 3'd0, 16'hBEEF, 16'h0001};
    tbl[10] = '{"rd3_beef",     1'b0, 1'b1, 3'd0, 3'd3, 16'h0000, 16'hBEEF};
    tbl[11] = '{"hold_wr3_0",   1'b1, 1'b0, 3'd3, 3'd1, 16'h0000, 16'hBEEF};
    tbl[12] = '{"hold_ra_tog",  1'b0, 1'b0, 3'd0, 3'd6, 16'h0000, 16'hBEEF};
    tbl[13] = '{"rd3_zero",     1'b0, 1'b1, 3'd0, 3'd3, 16'h0000, 16'h0000};

    // Initial clear pulse spanning one rising edge.
    #2 as_clr = 1'b1;
    #1;
    chk("reset_dout", dout, 16'h0000);
    model_clear();
    @(posedge clk);
    #3 as_clr = 1'b0;

    // Every address reads zero after clear.
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b1, 3'd0, 3'(a), 16'h0000);
      chk($sformatf("clr_rd%0d", a), dout, 16'h0000);
    end

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].wa, tbl[i].ra, tbl[i].d);
      chk(tbl[i].name, dout, tbl[i].exp);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           16'($urandom));
      chk("rand", dout, mdl_dout);
    end
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b1, 3'd0, 3'(a), 16'h0000);
      chk($sformatf("rand_final%0d", a), dout, mdl_mem[a]);
    end

    // Fill with nonzero words, leave dout nonzero, then clear between edges.
    for (int a = 0; a < 8; a++) begin
      step(1'b1, 1'b0, 3'(a), 3'd0, 16'(16'h1111 * (a + 1)));
    end
    step(1'b0, 1'b1, 3'd0, 3'd4, 16'h0000);
    chk("pre_clr_rd4", dout, 16'h5555);
    #2 as_clr = 1'b1;
    #1;
    chk("clr_midcycle", dout, 16'h0000);
    model_clear();
    // Write and read attempted while clear is held are both ignored.
    step(1'b1, 1'b1, 3'd4, 3'd4, 16'hFFFF);
    chk("clr_held_rd", dout, 16'h0000);
    #2 as_clr = 1'b0;
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 1'b1, 3'd0, 3'(a), 16'h0000);
      chk($sformatf("post_clr_rd%0d", a), dout, 16'h0000);
    end

    // First edge after release operates normally.
    step(1'b1, 1'b0, 3'd6, 3'd0, 16'hC0DE);
    step(1'b0, 1'b1, 3'd0, 3'd6, 16'h0000);
    chk("post_clr_wr_rd", dout, 16'hC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_ram.md
DUAL_RAM -- requirements
Module: dual_ram

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and as_clr.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-003 Parameter ADDR_W, default 3, SHALL set the address width.
REQ-004 Parameter DEPTH, default 8 (2**ADDR_W), SHALL set the number of words.
REQ-005 Ports SHALL appear in this positional order: din, dout, rd_addr, wr_addr, clk, we, re, as_clr.
REQ-006 clk: input, 1 bit, all synchronous activity on rising edge.
REQ-007 as_clr: input, 1 bit, asynchronous active-high clear.
REQ-008 din: input, DATA_W bits, write data.
REQ-009 dout: output, DATA_W bits, registered read data.
REQ-010 rd_addr: input, ADDR_W bits, read address.
REQ-011 wr_addr: input, ADDR_W bits, write address.
REQ-012 we: input, 1 bit, write enable, active high.
REQ-013 re: input, 1 bit, read enable, active high.

Function
REQ-014 Storage SHALL be DEPTH words of DATA_W bits, 8x16 at defaults.
REQ-015 Read and write ports SHALL operate independently in the same cycle.
REQ-016 When we=1 at a rising clk edge with as_clr=0, mem[wr_addr] SHALL take din.
REQ-017 When we=0, memory contents SHALL NOT change.
REQ-018 When re=1 at a rising clk edge with as_clr=0, dout SHALL take mem[rd_addr], giving one-cycle read latency.
REQ-019 When re=0, dout SHALL hold its previous value.
REQ-020 When we=1 and re=1 with rd_addr==wr_addr, dout SHALL return the old stored word (read-before-write); the new word is readable from the next edge.
REQ-021 Write and read to different addresses in the same cycle SHALL both complete with no interaction.
REQ-022 Addresses SHALL be fully decoded; every ADDR_W-bit value is valid and there is no out-of-range case at defaults.
REQ-023 Any nonzero value on we or re SHALL be treated as 1 (single-bit ports).
REQ-024 The block SHALL have no handshake and no back-pressure; every enabled access completes in the cycle it is presented.

Reset
REQ-025 Assertion of as_clr SHALL immediately, without waiting for a clock edge, clear dout and every memory word to 0.
REQ-026 While as_clr=1, writes and reads SHALL be ignored; dout stays 0 and memory stays 0.
REQ-027 After as_clr deasserts, the first rising edge SHALL perform normal operation.
REQ-028 as_clr asserted in the middle of a write cycle SHALL win, leaving the target word at 0.
REQ-029 Memory content before the first as_clr SHALL be treated as undefined; verification SHALL apply as_clr before checking.

Verification
REQ-030 Pulse as_clr for one cycle, then set re=1 and read addresses 0..7 -> dout=0x0000 for every address.
REQ-031 Write din=0x3524 at wr_addr=5 with we=1, then read rd_addr=5 with re=1 on the next cycle -> dout=0x3524 one edge after the read is sampled.
REQ-032 Write 0xA5A5 at address 2, then in one cycle write 0x1234 at address 2 while reading address 2 -> dout=0xA5A5 that edge, then 0x1234 on the following read.
REQ-033 Write 0xFFFF at address 7, then 0x0001 at address 0, then read both -> 0xFFFF and 0x0001, confirming no aliasing or wrap corruption.
REQ-034 After reading 0xBEEF, drop re, write 0x0000 to the same address, and toggle rd_addr -> dout remains 0xBEEF.
REQ-035 Fill memory with nonzero values, then assert as_clr between clock edges -> dout goes to 0 immediately, and all subsequent reads return 0x0000.
